// File: rtl/gpu_seq_pkg.sv
// Shared definitions for the GPU instruction sequencer.
//   DW_DEFAULT       - width of one PIO data word
//   DEPTH_DEFAULT    - FIFO entries (power of two, >= 2)
//   INSTR_W_DEFAULT  - stored instruction width, {data_b, data_a}
//   seq_state_e      - issue FSM state encoding
package gpu_seq_pkg;

    localparam int DW_DEFAULT      = 32;
    localparam int DEPTH_DEFAULT   = 16;
    localparam int INSTR_W_DEFAULT = 2 * DW_DEFAULT;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PRESENT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/gpu_instr_fifo.sv
// Synchronous FIFO holding captured GPU instructions.
// Read data is registered: a pop loads o_rd_data with the entry at the
// read pointer on the same edge that advances the pointer.
// Ports:
//   i_clk, i_reset   - clock, synchronous active-high reset
//   i_push, i_wr_data - write request and data (dropped when full)
//   i_pop            - read request (ignored when empty)
//   o_rd_data        - registered read data
//   o_full, o_empty  - status from start-of-cycle count
//   o_count          - stored entries
//   o_drop           - push arriving while full (combinational pulse)
module instr_fifo
    import gpu_seq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int W     = INSTR_W_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wr_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_rd_data;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_en;
    logic          w_rd_en;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is dropped even when an entry leaves on that edge.
    assign w_wr_en = i_push & ~w_full;
    assign w_rd_en = i_pop & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rptr    <= r_rptr + AW'(1);
                r_rd_data <= r_mem[r_rptr];
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;
    assign o_drop    = i_push & w_full;

endmodule

// File: rtl/gpu_instr_sequencer.sv
// Bridges the HPS PIO registers to the GPU instruction decoder.
// A rising edge of i_wrreg captures {i_data_b, i_data_a} into a FIFO; the
// issue FSM presents entries one at a time over a valid/ready handshake.
// Optional build macro: GPU_SEQ_DROP_CNT_EN adds o_drop_count, a saturating
// count of dropped pushes cleared by reset or i_ovf_clr.
// Ports:
//   i_clk, i_reset         - clock, synchronous active-high reset
//   i_data_a, i_data_b     - PIO data words (low, high)
//   i_wrreg                - PIO write strobe (level)
//   i_ovf_clr              - clears sticky overflow (and drop count)
//   o_instr_data/valid     - instruction presented to the GPU
//   i_instr_ready          - GPU accepts the presented instruction
//   o_fifo_full/empty/count - FIFO status (excludes presented entry)
//   o_overflow             - sticky: strobe edge arrived while full
//   o_drop_count           - dropped pushes (GPU_SEQ_DROP_CNT_EN only)
//
// Issue FSM:
//   state     | meaning
//   S_IDLE    | nothing in flight; pop as soon as the FIFO holds an entry
//   S_LOAD    | popped entry in FIFO read register; copy to output, raise valid
//   S_PRESENT | instruction held on the output until the GPU accepts it
module gpu_instr_sequencer
    import gpu_seq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [DW-1:0]          i_data_a,
    input  logic [DW-1:0]          i_data_b,
    input  logic                   i_wrreg,
    input  logic                   i_ovf_clr,
    output logic [2*DW-1:0]        o_instr_data,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    output logic                   o_fifo_full,
    output logic                   o_fifo_empty,
    output logic [$clog2(DEPTH):0] o_fifo_count,
    output logic                   o_overflow
`ifdef GPU_SEQ_DROP_CNT_EN
    ,
    output logic [15:0]            o_drop_count
`endif
);

    localparam int IW = 2 * DW;

    logic          r_wr_q;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_accept;
    logic          w_drop;
    logic          w_empty;
    logic [IW-1:0] w_rd_data;
    seq_state_e    r_state;
    seq_state_e    w_state_next;
    logic [IW-1:0] r_instr_data;
    logic          r_instr_valid;
    logic          r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_q <= 1'b0;
        end else begin
            r_wr_q <= i_wrreg;
        end
    end

    assign w_push = i_wrreg & ~r_wr_q;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (IW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_push    (w_push),
        .i_wr_data ({i_data_b, i_data_a}),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (o_fifo_full),
        .o_empty   (w_empty),
        .o_count   (o_fifo_count),
        .o_drop    (w_drop)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load       = 1'b1;
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (i_instr_ready) begin
                    w_accept = 1'b1;
                    if (!w_empty) begin
                        // Fetch the next entry now; valid drops for one
                        // bubble cycle while it moves through S_LOAD.
                        w_pop        = 1'b1;
                        w_state_next = S_LOAD;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output data is only rewritten on load, so it holds its last value
    // while valid is low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instr_data  <= '0;
            r_instr_valid <= 1'b0;
        end else if (w_load) begin
            r_instr_data  <= w_rd_data;
            r_instr_valid <= 1'b1;
        end else if (w_accept) begin
            r_instr_valid <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear wins, so software never misses it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef GPU_SEQ_DROP_CNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_drop_count <= '0;
        end else if (i_ovf_clr) begin
            r_drop_count <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_drop_count = r_drop_count;
`endif

    assign o_instr_data  = r_instr_data;
    assign o_instr_valid = r_instr_valid;
    assign o_fifo_empty  = w_empty;
    assign o_overflow    = r_overflow;

endmodule

// File: doc/gpu_instr_sequencer.md
Name: gpu_instr_sequencer

Overview:
- Sits between the HPS-facing PIO output registers (data A, data B, write strobe) and the GPU instruction decoder.
- Detects each rising edge of the software write-strobe and captures the 64-bit instruction {data_b, data_a}.
- Buffers captured instructions in a small FIFO and issues them one at a time to the GPU over a valid/ready handshake.
- Reports full/overflow status back to software through a readback PIO.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- DW, 32, width of each PIO data word; stored instruction width is 2*DW.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data_a  in  DW  PIO data A (low instruction word).
- data_b  in  DW  PIO data B (high instruction word).
- wrreg  in  1  PIO write strobe, level; one instruction per 0->1 transition.
- ovf_clr  in  1  single-cycle pulse; clears the sticky overflow flag.
- instr_data  out  2*DW  {data_b, data_a} presented to the GPU.
- instr_valid  out  1  instr_data is valid.
- instr_ready  in  1  GPU accepts the instruction this cycle.
- fifo_full  out  1  no free entry.
- fifo_empty  out  1  no stored entry (excludes the presented instruction).
- fifo_count  out  $clog2(DEPTH)+1  stored entries.
- overflow  out  1  sticky: a strobe edge arrived while full.

Behaviour:
- Reset (synchronous, active-high, every cycle asserted):
  - Outputs: instr_data=0, instr_valid=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0.
  - Internal state: wr_q=0, pointers=0, FSM=S_IDLE.
- Edge detect:
  - wr_q <= wrreg every cycle; push = wrreg & ~wr_q.
  - A held-high wrreg pushes once. wrreg high out of reset pushes in the first cycle after reset deasserts.
- Push:
  - In the push cycle, if not full: write {data_b,data_a} at wptr and increment wptr (wraps modulo DEPTH).
  - If full: drop the write and set overflow=1.
  - Fullness is judged on start-of-cycle state. A push while full is dropped even if a pop occurs in the same cycle.
- Overflow flag:
  - overflow clears on ovf_clr.
  - If ovf_clr and a dropped push coincide, set wins.
- Count:
  - +1 on push only, -1 on pop only, unchanged when both occur.
  - fifo_full = (count==DEPTH); fifo_empty = (count==0).
- Issue FSM:
  - S_IDLE: if !empty, assert pop (rptr++), go to S_LOAD.
  - S_LOAD: instr_data <= mem[old rptr], instr_valid <= 1, go to S_PRESENT.
  - S_PRESENT: hold instr_data and instr_valid stable until instr_ready=1.
    - On acceptance, if !empty: pop again, drop instr_valid, go to S_LOAD.
    - On acceptance, if empty: drop instr_valid, go to S_IDLE.
  - One handshake per instruction. One bubble cycle between consecutive instructions is required.
  - instr_data keeps its last value while instr_valid=0.
- Latency: push in cycle N -> instr_valid=1 in cycle N+2 (FIFO previously empty, FSM idle).
- Simultaneous push and pop on an empty FIFO is impossible by construction (pop needs !empty at start of cycle).
- Reset mid-handshake: the presented instruction and all FIFO contents are discarded; instr_valid falls on the next edge.
- instr_ready is ignored when instr_valid=0.

Optional Feature:
- Macro: GPU_SEQ_DROP_CNT_EN.
- When defined:
  - Adds output drop_count [15:0], which counts every dropped push and saturates at 16'hFFFF.
  - drop_count resets to 0 on reset and on ovf_clr.
  - If ovf_clr and a drop coincide, drop_count becomes 1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gpu_seq_pkg:
  - DW and DEPTH defaults.
  - Instruction width constant.
  - FSM state enum {S_IDLE, S_LOAD, S_PRESENT}.
- Sub-module instr_fifo: synchronous FIFO with registered read data, pointers and count, and a full-drop/overflow output.
- The top level holds the edge detector, the issue FSM and the optional drop counter.

Test Plan:
- Single write: data_a=32'h0000_1234, data_b=32'hABCD_0000, wrreg 0->1 in cycle N -> instr_valid=1 at N+2 with instr_data=64'hABCD_0000_0000_1234; instr_ready=1 -> instr_valid=0 next cycle, fifo_empty=1.
- Held strobe: wrreg held high for 10 cycles -> exactly one instruction issued; fifo_count peaks at 1.
- Backpressure: instr_ready=0, 17 strobe edges with data_a=1..17 (DEPTH=16):
  - Instruction 1 is presented; items 2..17 fill the FIFO (fifo_full=1, overflow=0).
  - An 18th edge -> overflow=1, data dropped.
  - Release ready -> order 1..17 with no loss.
- Push/pop concurrency: full FIFO, push on the same cycle as an accepted pop -> push dropped, overflow=1, fifo_count goes 16->15.
- Overflow clear: ovf_clr pulse -> overflow=0. ovf_clr coincident with a dropped push -> overflow stays 1. With GPU_SEQ_DROP_CNT_EN: 3 drops -> drop_count=3; ovf_clr -> 0.
- Reset mid-operation: 5 queued, instr_valid=1, reset for 1 cycle -> instr_valid=0, fifo_count=0, fifo_empty=1; subsequent strobe issues the new data only.
